// File: rtl/psdsqrt_pkg.sv
// rtl/psdsqrt_pkg.sv - shared types and constants for the psdsqrt scheduler
package psdsqrt_pkg;

    localparam int NUMBITS_DEF   = 32;
    localparam int NREQ_DEF      = 4;
    localparam int SQ_CYCLES_DEF = 16;

    // Width of an index/counter, never narrower than one bit
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int CNT_W = $clog2(SQ_CYCLES_DEF + 1);
    localparam int ID_W  = clog2_min1(NREQ_DEF);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_RUN   = 3'd2,
        S_STOP  = 3'd3,
        S_DONE  = 3'd4
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter searching from ptr
module rr_arbiter
    import psdsqrt_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = clog2_min1(NREQ)
) (
    input  logic [NREQ-1:0] req_m,
    input  logic [IW-1:0]   ptr,
    output logic            grant_valid,
    output logic [IW-1:0]   grant_id
);

    logic [IW-1:0] idx;

    // Walk offsets from the far end down so the requester closest to ptr wins
    always_comb begin
        grant_valid = 1'b0;
        grant_id    = '0;
        idx         = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = IW'((int'(ptr) + i) % NREQ);
            if (req_m[idx]) begin
                grant_valid = 1'b1;
                grant_id    = idx;
            end
        end
    end

endmodule

// File: rtl/psdsqrt_sched.sv
// rtl/psdsqrt_sched.sv - round-robin sharing of one psdsqrt unit between NREQ clients
module psdsqrt_sched
    import psdsqrt_pkg::*;
#(
    parameter int NUMBITS   = NUMBITS_DEF,
    parameter int NREQ      = NREQ_DEF,
    parameter int SQ_CYCLES = SQ_CYCLES_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*NUMBITS-1:0] req_x,
    output logic [NREQ-1:0]         done,
    output logic [NUMBITS/2-1:0]    result,
    output logic                    busy,
    output logic                    sq_start,
    output logic                    sq_stop,
    output logic [NUMBITS-1:0]      sq_xin,
    input  logic [NUMBITS/2-1:0]    sq_result
);

    localparam int IW = clog2_min1(NREQ);
    localparam int CW = $clog2(SQ_CYCLES + 1);

    sched_state_t    state, state_nxt;
    logic [CW-1:0]   cnt;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   owner;
    logic [NREQ-1:0] req_m;
    logic            grant_valid;
    logic [IW-1:0]   grant_id;

    // A requester being acknowledged this cycle must not win again on a stale req
    assign req_m = req & ~done;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_arb (
        .req_m       (req_m),
        .ptr         (ptr),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: fixed START/RUN/STOP/DONE sequence once a grant is made
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant_valid) state_nxt = S_START;
            S_START: state_nxt = S_RUN;
            S_RUN:   if (cnt == CW'(1)) state_nxt = S_STOP;
            S_STOP:  state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Registered outputs, operand/result capture, pointer and window counter
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr      <= '0;
            owner    <= '0;
            cnt      <= '0;
            sq_start <= 1'b0;
            sq_stop  <= 1'b0;
            sq_xin   <= '0;
            done     <= '0;
            result   <= '0;
            busy     <= 1'b0;
        end else begin
            busy     <= (state_nxt != S_IDLE);
            sq_start <= (state_nxt == S_START);
            sq_stop  <= (state_nxt == S_STOP);
            done     <= '0;
            case (state)
                S_IDLE: begin
                    if (grant_valid) begin
                        sq_xin <= req_x[int'(grant_id)*NUMBITS +: NUMBITS];
                        owner  <= grant_id;
                        ptr    <= (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + IW'(1);
                    end
                end
                S_START: cnt <= CW'(SQ_CYCLES);
                S_RUN:   cnt <= cnt - CW'(1);
                S_DONE: begin
                    result <= sq_result;
                    done   <= NREQ'(1) << owner;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_psdsqrt_sched.sv
// tb/tb_psdsqrt_sched.sv - directed self-checking bench for psdsqrt_sched
module tb_psdsqrt_sched;
    import psdsqrt_pkg::*;

    logic         clock = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [127:0] req_x;
    logic [3:0]   done;
    logic [15:0]  result;
    logic         busy;
    logic         sq_start;
    logic         sq_stop;
    logic [31:0]  sq_xin;
    logic [15:0]  sq_result;

    int total = 0;
    int bad   = 0;
    int n;
    logic        prev_busy = 1'b0;
    logic [31:0] prev_xin  = '0;

    psdsqrt_sched dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .req_x     (req_x),
        .done      (done),
        .result    (result),
        .busy      (busy),
        .sq_start  (sq_start),
        .sq_stop   (sq_stop),
        .sq_xin    (sq_xin),
        .sq_result (sq_result)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] isqrt(input logic [31:0] x);
        logic [15:0] r;
        logic [15:0] t;
        r = '0;
        for (int b = 15; b >= 0; b--) begin
            t = r | (16'd1 << b);
            if (64'(t) * 64'(t) <= 64'(x)) r = t;
        end
        return r;
    endfunction

    // Square-root unit stand-in: root becomes visible only after the stop pulse
    always @(posedge clock) begin
        if (sq_stop) sq_result <= isqrt(sq_xin);
        else if (sq_start) sq_result <= '0;
    end

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Operand must hold steady for the whole operation
    always @(negedge clock) begin
        if (busy && prev_busy && !sq_start) check("xin_stable", sq_xin, prev_xin);
        prev_busy = busy;
        prev_xin  = sq_xin;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (done == 4'd0 && cycles < 60);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic serve(input int i, input logic [31:0] x, input logic [15:0] exp, input string tag);
        int c;
        req_x[i*32 +: 32] = x;
        req[i] = 1'b1;
        wait_done(c);
        check({tag, "_lat"}, c, 20);
        check({tag, "_done"}, done, 4'd1 << i);
        check({tag, "_res"}, result, exp);
        req[i] = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        req_x = '0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_start", sq_start, 0);
        check("rst_stop", sq_stop, 0);
        check("rst_xin", sq_xin, 0);
        reset = 1'b0;
        tick();

        // single request timeline, cycle 0 is the first cycle req is seen
        req_x[31:0] = 32'd625;
        req = 4'b0001;
        for (int c = 1; c <= 20; c++) begin
            tick();
            if (c == 1) begin
                check("t1_start", sq_start, 1);
                check("t1_xin", sq_xin, 625);
            end
            if (c == 2)  check("t1_start_clr", sq_start, 0);
            if (c == 17) check("t1_nostop", sq_stop, 0);
            if (c == 18) check("t1_stop", sq_stop, 1);
            if (c == 19) check("t1_busy", busy, 1);
            if (c == 19) check("t1_early", done, 0);
            if (c == 20) begin
                check("t1_done", done, 4'b0001);
                check("t1_res", result, 25);
                check("t1_idle", busy, 0);
            end
        end
        req = '0;
        tick();
        check("t1_strobe", done, 0);
        check("t1_hold", result, 25);

        // boundary operands through requester 2
        serve(2, 32'd0, 16'd0, "b0");
        serve(2, 32'd1, 16'd1, "b1");
        serve(2, 32'hFFFF_FFFF, 16'd65535, "bmax");
        serve(2, 32'h3FFF_FFFF, 16'd32767, "b3f");

        // all four at once after reset: service order 0,1,2,3
        do_reset();
        req_x = {32'd81, 32'd49, 32'd16, 32'd9};
        req = 4'b1111;
        for (int k = 0; k < 4; k++) begin
            wait_done(n);
            check("rr_gap", n, 20);
            check("rr_owner", done, 4'd1 << k);
            case (k)
                0: check("rr_res0", result, 3);
                1: check("rr_res1", result, 4);
                2: check("rr_res2", result, 7);
                default: check("rr_res3", result, 9);
            endcase
            req[k] = 1'b0;
        end
        tick();
        check("rr_norepeat", busy, 0);

        // requester 1 holds req across two operations
        req_x[63:32] = 32'd100;
        req[1] = 1'b1;
        tick();
        check("hold_start1", sq_start, 1);
        req_x[63:32] = 32'd144;
        wait_done(n);
        check("hold_lat1", n, 19);
        check("hold_res1", result, 10);
        tick();
        check("hold_masked", sq_start, 0);
        tick();
        check("hold_start2", sq_start, 1);
        wait_done(n);
        check("hold_lat2", n, 19);
        check("hold_res2", result, 12);
        req[1] = 1'b0;
        tick();

        // reset in the middle of an operation
        req_x[31:0] = 32'd10000;
        req[0] = 1'b1;
        for (int c = 1; c <= 10; c++) tick();
        reset = 1'b1;
        tick();
        check("mrst_busy", busy, 0);
        check("mrst_start", sq_start, 0);
        check("mrst_stop", sq_stop, 0);
        check("mrst_xin", sq_xin, 0);
        check("mrst_done", done, 0);
        check("mrst_result", result, 0);
        check("mrst_state", dut.state, S_IDLE);
        check("mrst_ptr", dut.ptr, 0);
        reset = 1'b0;
        wait_done(n);
        check("mrst_lat", n, 20);
        check("mrst_owner", done, 4'b0001);
        check("mrst_res", result, 100);
        req[0] = 1'b0;
        tick();

        // operand changed right after grant must not leak into the result
        req_x[127:96] = 32'd50625;
        req[3] = 1'b1;
        tick();
        check("latch_start", sq_start, 1);
        req_x[127:96] = 32'd1;
        wait_done(n);
        check("latch_lat", n, 19);
        check("latch_owner", done, 4'b1000);
        check("latch_res", result, 225);
        req[3] = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
